// File: rtl/otter_wb_pkg.sv
// Shared types and constants for the OTTER writeback stage.
package otter_wb_pkg;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2,
      WB_CSR  = 2'd3
   } wb_sel_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      WRITE    = 2'd2
   } wb_state_t;

endpackage

// File: rtl/otter_writeback_stage_if.sv
// Bundle of execute handshake, memory response and register-file write signals.
interface otter_writeback_stage_if #(
   parameter int XLEN = 32
) ();

   logic            wb_valid;
   logic            wb_ready;
   logic [1:0]      wb_sel;
   logic [4:0]      wb_rd;
   logic            wb_reg_write;
   logic [XLEN-1:0] alu_result;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] csr_rdata;
   logic [2:0]      load_funct3;
   logic            mem_rvalid;
   logic [XLEN-1:0] mem_rdata;
   logic            rf_write;
   logic [4:0]      rf_wreg;
   logic [XLEN-1:0] rf_wdata;
   logic            wb_done;
   logic            load_err;

   modport master (
      output wb_valid, wb_sel, wb_rd, wb_reg_write, alu_result, pc_plus4,
             csr_rdata, load_funct3, mem_rvalid, mem_rdata,
      input  wb_ready, rf_write, rf_wreg, rf_wdata, wb_done, load_err
   );

   modport slave (
      input  wb_valid, wb_sel, wb_rd, wb_reg_write, alu_result, pc_plus4,
             csr_rdata, load_funct3, mem_rvalid, mem_rdata,
      output wb_ready, rf_write, rf_wreg, rf_wdata, wb_done, load_err
   );

endinterface

// File: rtl/otter_load_align.sv
// Byte/half/word lane selection and sign/zero extension of a raw load word,
// flagging misaligned halves/words and unsupported funct3 codes.
module otter_load_align
   import otter_wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_mem_rdata,
   input  logic [1:0]      i_addr,
   input  logic [2:0]      i_funct3,
   output logic [XLEN-1:0] o_data,
   output logic            o_err
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_mem_rdata[{i_addr, 3'b000} +: 8];
   assign w_half = i_mem_rdata[{i_addr[1], 4'b0000} +: 16];

   always_comb begin
      o_data = '0;
      o_err  = 1'b0;
      case (i_funct3)
         F3_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
         F3_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
         F3_LH: begin
            o_data = {{(XLEN-16){w_half[15]}}, w_half};
            o_err  = i_addr[0];
         end
         F3_LHU: begin
            o_data = {{(XLEN-16){1'b0}}, w_half};
            o_err  = i_addr[0];
         end
         F3_LW: begin
            o_data = i_mem_rdata;
            o_err  = |i_addr;
         end
         default: o_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/otter_writeback_stage.sv
// OTTER writeback stage: accepts a retired instruction, waits for load data
// when needed, and drives the register-file write port for one WRITE cycle.
module otter_writeback_stage
   import otter_wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                   clock,
   input  logic                   reset_n,
   otter_writeback_stage_if.slave bus
);

   wb_state_t       r_state;
   wb_state_t       w_next;
   logic [4:0]      r_rd;
   logic            r_reg_write;
   wb_sel_t         r_sel;
   logic [XLEN-1:0] r_alu;
   logic [XLEN-1:0] r_pc4;
   logic [XLEN-1:0] r_csr;
   logic [XLEN-1:0] r_load;
   logic [2:0]      r_funct3;
   logic            r_err;

   logic            w_accept;
   logic            w_mem_take;
   logic [XLEN-1:0] w_align_data;
   logic            w_align_err;
   logic [XLEN-1:0] w_result;

   assign w_accept   = (r_state == IDLE) && bus.wb_valid;
   assign w_mem_take = (r_state == WAIT_MEM) && bus.mem_rvalid;

   otter_load_align #(.XLEN(XLEN)) u_align (
      .i_mem_rdata (bus.mem_rdata),
      .i_addr      (r_alu[1:0]),
      .i_funct3    (r_funct3),
      .o_data      (w_align_data),
      .o_err       (w_align_err)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (bus.wb_valid)
               w_next = (wb_sel_t'(bus.wb_sel) == WB_LOAD) ? WAIT_MEM : WRITE;
         end
         WAIT_MEM: if (bus.mem_rvalid) w_next = WRITE;
         WRITE:    w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   // Capture registers stay untouched until the next accept, so rf_wreg/rf_wdata hold.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rd        <= '0;
         r_reg_write <= 1'b0;
         r_sel       <= WB_ALU;
         r_alu       <= '0;
         r_pc4       <= '0;
         r_csr       <= '0;
         r_load      <= '0;
         r_funct3    <= '0;
         r_err       <= 1'b0;
      end else if (w_accept) begin
         r_rd        <= bus.wb_rd;
         r_reg_write <= bus.wb_reg_write;
         r_sel       <= wb_sel_t'(bus.wb_sel);
         r_alu       <= bus.alu_result;
         r_pc4       <= bus.pc_plus4;
         r_csr       <= bus.csr_rdata;
         r_funct3    <= bus.load_funct3;
         r_err       <= 1'b0;
      end else if (w_mem_take) begin
         r_load      <= w_align_data;
         r_err       <= w_align_err;
      end
   end

   always_comb begin
      w_result = r_alu;
      case (r_sel)
         WB_ALU:  w_result = r_alu;
         WB_LOAD: w_result = r_load;
         WB_PC4:  w_result = r_pc4;
         WB_CSR:  w_result = r_csr;
         default: w_result = r_alu;
      endcase
   end

   // Every output is a function of registers only, so it is settled well before the negedge write.
   assign bus.wb_ready = (r_state == IDLE);
   assign bus.wb_done  = (r_state == WRITE);
   assign bus.load_err = (r_state == WRITE) && r_err;
   assign bus.rf_write = (r_state == WRITE) && r_reg_write && (r_rd != 5'd0) && !r_err;
   assign bus.rf_wreg  = r_rd;
   assign bus.rf_wdata = w_result;

endmodule

// File: tb/tb_otter_writeback_stage.sv
// Scoreboard bench for otter_writeback_stage: directed instructions push their
// expected register-file write; a negedge monitor checks each wb_done pulse.
module tb_otter_writeback_stage;

   typedef struct {
      logic        wr;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      logic        err;
   } exp_t;

   logic clock = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   exp_t mon_e;

   otter_writeback_stage_if #(.XLEN(32)) bus ();

   otter_writeback_stage #(.XLEN(32)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (reset_n === 1'b1 && bus.wb_done === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: wb_done=1 with no instruction outstanding (rf_wreg=%0d)", bus.rf_wreg);
         end else begin
            mon_e = q.pop_front();
            chk("rf_write", {31'd0, bus.rf_write}, {31'd0, mon_e.wr});
            chk("rf_wreg",  {27'd0, bus.rf_wreg},  {27'd0, mon_e.wreg});
            chk("load_err", {31'd0, bus.load_err}, {31'd0, mon_e.err});
            if (!mon_e.err) chk("rf_wdata", bus.rf_wdata, mon_e.wdata);
         end
      end
   end

   // Called at a negedge; returns at the negedge of the instruction's WRITE cycle.
   task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic rw,
                        input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] csr,
                        input logic [2:0] f3, input logic [31:0] mdata, input int lat,
                        input logic ewr, input logic [31:0] ewdata, input logic eerr);
      exp_t e;
      int   n;
      n = 0;
      while (bus.wb_ready !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (bus.wb_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: wb_ready=%b expected 1", bus.wb_ready);
      end
      bus.wb_sel       = sel;
      bus.wb_rd        = rd;
      bus.wb_reg_write = rw;
      bus.alu_result   = alu;
      bus.pc_plus4     = pc4;
      bus.csr_rdata    = csr;
      bus.load_funct3  = f3;
      bus.wb_valid     = 1'b1;
      e.wr = ewr; e.wreg = rd; e.wdata = ewdata; e.err = eerr;
      q.push_back(e);
      @(posedge clock);
      #1 bus.wb_valid = 1'b0;
      @(negedge clock);
      if (sel == 2'd1) begin
         for (int i = 1; i < lat; i++) @(negedge clock);
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = mdata;
         @(posedge clock);
         #1 bus.mem_rvalid = 1'b0;
         @(negedge clock);
      end
   endtask

   initial begin
      logic seen;
      int   n;
      reset_n          = 1'b0;
      bus.wb_valid     = 1'b0;
      bus.wb_sel       = 2'd0;
      bus.wb_rd        = 5'd0;
      bus.wb_reg_write = 1'b0;
      bus.alu_result   = '0;
      bus.pc_plus4     = '0;
      bus.csr_rdata    = '0;
      bus.load_funct3  = 3'd0;
      bus.mem_rvalid   = 1'b0;
      bus.mem_rdata    = '0;

      repeat (2) @(negedge clock);
      chk("rst_rf_write", {31'd0, bus.rf_write}, 32'd0);
      chk("rst_rf_wreg",  {27'd0, bus.rf_wreg},  32'd0);
      chk("rst_rf_wdata", bus.rf_wdata,          32'd0);
      chk("rst_wb_done",  {31'd0, bus.wb_done},  32'd0);
      chk("rst_load_err", {31'd0, bus.load_err}, 32'd0);
      chk("rst_wb_ready", {31'd0, bus.wb_ready}, 32'd1);
      reset_n = 1'b1;
      @(negedge clock);

      // sel, rd, rw, alu, pc4, csr, f3, mdata, lat, exp wr, exp wdata, exp err
      issue(2'd0, 5'd5,  1'b1, 32'h1234_5678, 32'h0, 32'h0, 3'b000, 32'h0,         0, 1'b1, 32'h1234_5678, 1'b0);
      issue(2'd1, 5'd6,  1'b1, 32'h0000_1003, 32'h0, 32'h0, 3'b000, 32'h80FF_FFFF, 1, 1'b1, 32'hFFFF_FF80, 1'b0);
      issue(2'd1, 5'd6,  1'b1, 32'h0000_1003, 32'h0, 32'h0, 3'b100, 32'h80FF_FFFF, 1, 1'b1, 32'h0000_0080, 1'b0);
      issue(2'd1, 5'd8,  1'b1, 32'h0000_1002, 32'h0, 32'h0, 3'b101, 32'hBEEF_0000, 1, 1'b1, 32'h0000_BEEF, 1'b0);
      issue(2'd1, 5'd8,  1'b1, 32'h0000_1002, 32'h0, 32'h0, 3'b001, 32'hBEEF_0000, 3, 1'b1, 32'hFFFF_BEEF, 1'b0);
      issue(2'd1, 5'd9,  1'b1, 32'h0000_1002, 32'h0, 32'h0, 3'b010, 32'hDEAD_BEEF, 1, 1'b0, 32'h0,         1'b1);
      issue(2'd1, 5'd10, 1'b1, 32'h0000_2000, 32'h0, 32'h0, 3'b010, 32'hDEAD_BEEF, 2, 1'b1, 32'hDEAD_BEEF, 1'b0);
      issue(2'd1, 5'd11, 1'b1, 32'h0000_0001, 32'h0, 32'h0, 3'b000, 32'h0000_7F00, 1, 1'b1, 32'h0000_007F, 1'b0);
      issue(2'd1, 5'd12, 1'b1, 32'h0000_0001, 32'h0, 32'h0, 3'b001, 32'h1234_5678, 1, 1'b0, 32'h0,         1'b1);
      issue(2'd1, 5'd13, 1'b1, 32'h0000_0000, 32'h0, 32'h0, 3'b011, 32'h1234_5678, 1, 1'b0, 32'h0,         1'b1);
      issue(2'd2, 5'd14, 1'b1, 32'h0,         32'h0000_0104, 32'h0, 3'b000, 32'h0, 0, 1'b1, 32'h0000_0104, 1'b0);
      issue(2'd3, 5'd15, 1'b1, 32'h0,         32'h0, 32'hCAFE_BABE, 3'b000, 32'h0, 0, 1'b1, 32'hCAFE_BABE, 1'b0);
      issue(2'd0, 5'd3,  1'b0, 32'h5555_AAAA, 32'h0, 32'h0, 3'b000, 32'h0,         0, 1'b0, 32'h5555_AAAA, 1'b0);
      issue(2'd2, 5'd0,  1'b1, 32'h0,         32'h0000_0100, 32'h0, 3'b000, 32'h0, 0, 1'b0, 32'h0000_0100, 1'b0);

      // Now in the WRITE cycle of the rd=0 instruction: a wb_valid here must be ignored.
      chk("ready_in_write", {31'd0, bus.wb_ready}, 32'd0);
      bus.wb_sel = 2'd0; bus.wb_rd = 5'd7; bus.wb_reg_write = 1'b1;
      bus.alu_result = 32'h7777_7777; bus.wb_valid = 1'b1;
      @(posedge clock);
      #1 bus.wb_valid = 1'b0;
      @(negedge clock);
      chk("ignored_valid_ready", {31'd0, bus.wb_ready}, 32'd1);
      chk("ignored_valid_done",  {31'd0, bus.wb_done},  32'd0);
      issue(2'd0, 5'd20, 1'b1, 32'h0BAD_F00D, 32'h0, 32'h0, 3'b000, 32'h0, 0, 1'b1, 32'h0BAD_F00D, 1'b0);

      // Reset while waiting for load data aborts the instruction.
      @(negedge clock);
      bus.wb_sel = 2'd1; bus.wb_rd = 5'd21; bus.wb_reg_write = 1'b1;
      bus.alu_result = 32'h0; bus.load_funct3 = 3'b010; bus.wb_valid = 1'b1;
      @(posedge clock);
      #1 bus.wb_valid = 1'b0;
      @(negedge clock);
      chk("wait_mem_ready", {31'd0, bus.wb_ready}, 32'd0);
      reset_n = 1'b0;
      #1;
      chk("midrst_rf_write", {31'd0, bus.rf_write}, 32'd0);
      chk("midrst_rf_wreg",  {27'd0, bus.rf_wreg},  32'd0);
      chk("midrst_rf_wdata", bus.rf_wdata,          32'd0);
      chk("midrst_wb_done",  {31'd0, bus.wb_done},  32'd0);
      chk("midrst_load_err", {31'd0, bus.load_err}, 32'd0);
      chk("midrst_wb_ready", {31'd0, bus.wb_ready}, 32'd1);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_2222;
      @(posedge clock);
      #1 bus.mem_rvalid = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clock);
         if (bus.rf_write !== 1'b0 || bus.wb_done !== 1'b0) seen = 1'b1;
      end
      chk("post_rst_no_write", {31'd0, seen}, 32'd0);
      issue(2'd0, 5'd22, 1'b1, 32'h00C0_FFEE, 32'h0, 32'h0, 3'b000, 32'h0, 0, 1'b1, 32'h00C0_FFEE, 1'b0);

      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/otter_writeback_stage.md
# otter_writeback_stage

Writeback stage of the multicycle OTTER core, sitting directly upstream of the register file. It accepts a completed instruction from execute with a valid/ready handshake and selects the result source: ALU, load data, PC+4 or CSR. For loads it waits for the memory response, then byte-aligns and sign- or zero-extends the data. It drives the register file write port (write enable, register index, data), stable across the file's negedge write.

## Interface
Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- wb_valid  in  1  execute presents a completed instruction.
- wb_ready  out  1  stage can accept; high only in IDLE.
- wb_sel  in  2  result source: 0 ALU, 1 LOAD, 2 PC4, 3 CSR.
- wb_rd  in  5  destination register.
- wb_reg_write  in  1  instruction writes rd.
- alu_result  in  XLEN  ALU result; also the load address.
- pc_plus4  in  XLEN  PC+4 for JAL/JALR.
- csr_rdata  in  XLEN  CSR read value.
- load_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  XLEN  raw aligned memory word.
- rf_write  out  1  register-file write enable.
- rf_wreg  out  5  register-file write index.
- rf_wdata  out  XLEN  register-file write data.
- wb_done  out  1  one-cycle pulse when an instruction retires.
- load_err  out  1  one-cycle pulse on a misaligned or illegal load.

## Operation
- The FSM has three states: IDLE, WAIT_MEM, WRITE.
- IDLE:
  - wb_ready=1.
  - When wb_valid is high, capture rd, reg_write, sel, alu_result, pc_plus4, csr_rdata and funct3.
  - If sel=LOAD, go to WAIT_MEM. Otherwise latch the selected source into the result register and go to WRITE.
- WAIT_MEM:
  - When mem_rvalid is high, latch the aligned and extended mem_rdata and go to WRITE.
  - Otherwise stay in WAIT_MEM (no timeout).
- WRITE:
  - rf_write = reg_write && rd!=0 && !err.
  - wb_done=1; load_err=err.
  - Next state is IDLE.
- Load alignment uses lane = addr[1:0]:
  - LB/LBU take byte mem_rdata[8*lane+:8].
  - LH/LHU take half mem_rdata[16*addr[1]+:16].
  - LW takes the full word.
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
- Errors set err and suppress the write; wb_done still pulses:
  - LH/LHU with addr[0]=1.
  - LW with addr[1:0]!=0.
  - funct3 of 011, 110 or 111.
- rf_wreg and rf_wdata come from the captured/result registers. They are held from capture until the next accept.
- Ignored inputs:
  - wb_valid outside IDLE.
  - mem_rvalid outside WAIT_MEM.
- Reset values: state=IDLE, all captured registers 0, rf_write=0, rf_wreg=0, rf_wdata=0, wb_done=0, load_err=0, wb_ready=1.

## Timing
- Non-load: accept at edge N → WRITE during cycle N+1 (rf_write, wb_done). Back in IDLE at N+2. Throughput is one instruction per 2 cycles.
- Load: accept at N → WAIT_MEM during N+1. mem_rvalid sampled at edge M → WRITE during cycle M+1. With 1-cycle memory, M=N+1, so the load latency is 2 cycles.
- rf_write, rf_wreg and rf_wdata are registered and stable for the whole WRITE cycle, so the register file's negedge write sees settled values.
- Reset mid-operation (WAIT_MEM or WRITE) aborts immediately. No write occurs, and the stage returns to IDLE on release.
- rd=0 with reg_write=1 gives rf_write=0 and wb_done=1.

## Structure
- Shared package otter_wb_pkg:
  - wb_sel_t enum {WB_ALU, WB_LOAD, WB_PC4, WB_CSR}.
  - Load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - wb_state_t enum {IDLE, WAIT_MEM, WRITE}.
- Sub-module otter_load_align (combinational):
  - Inputs: mem_rdata, addr[1:0], funct3.
  - Outputs: extended data and a misaligned/illegal flag.
- The FSM and capture registers stay in the top module.

## Test plan
- Reset: assert reset_n=0 mid-WAIT_MEM → all outputs 0, wb_ready=1. With mem_rvalid then pulsed after release, no rf_write.
- ALU write: sel=ALU, rd=5, alu_result=0x1234_5678 → next cycle rf_write=1, rf_wreg=5, rf_wdata=0x1234_5678, wb_done=1.
- LB sign extension: addr=0x...3, mem_rdata=0x80FF_FFFF, rvalid the following cycle → rf_wdata=0xFFFF_FF80. LBU on the same word → 0x0000_0080.
- LHU: addr[1]=1, mem_rdata=0xBEEF_0000 → rf_wdata=0x0000_BEEF. LH on the same word → 0xFFFF_BEEF.
- Misaligned LW: addr=0x...2 → rf_write=0, load_err=1, wb_done=1.
- rd=0 with sel=PC4 → rf_write=0, wb_done=1. A wb_valid pulse during WRITE is ignored, and the next accept happens only from IDLE.
